// File: rtl/alu_pkg.sv
// Shared ALU definitions: alu_ctrl codes (common with the ALU control decoder)
// and the sequencing FSM state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: logic, add/sub, compares and illegal-code detect.
// Shift codes pass op_a through; the iterative shift lives in seq_alu.
module alu_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_ctrl)
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_XOR:  result = op_a ^ op_b;
      ALU_SLT:  result[0] = $signed(op_a) < $signed(op_b);
      ALU_SLTU: result[0] = op_a < op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: result = op_a;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential execution-stage ALU: one-cycle logic/arith/compare ops, one-bit-per-cycle
// shifts, and a valid/ready handshake on both sides.
module seq_alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  state_t          state_reg, state_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic            illegal_reg, illegal_next;
  logic [SHW-1:0]  cnt_reg, cnt_next;
  logic [3:0]      sh_op_reg, sh_op_next;
  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] comb_result;
  logic            comb_illegal;

  alu_comb #(.XLEN(XLEN)) u_comb (
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .result   (comb_result),
    .illegal  (comb_illegal)
  );

  assign shamt  = op_b[SHW-1:0];
  assign accept = in_valid && in_ready;

  // in_ready depends only on state and out_ready, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (state_reg)
      S_IDLE:  in_ready = 1'b1;
      S_DONE:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    result_next  = result_reg;
    illegal_next = illegal_reg;
    cnt_next     = cnt_reg;
    sh_op_next   = sh_op_reg;

    case (state_reg)
      S_SHIFT: begin
        // result_reg doubles as the shift register while out_valid is low.
        case (sh_op_reg)
          ALU_SRL: result_next = {1'b0, result_reg[XLEN-1:1]};
          ALU_SRA: result_next = {result_reg[XLEN-1], result_reg[XLEN-1:1]};
          default: result_next = {result_reg[XLEN-2:0], 1'b0};
        endcase
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == SHW'(1)) state_next = S_DONE;
      end
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: ;
    endcase

    // Accept from IDLE or from DONE while retiring; both start the same way.
    if (accept) begin
      if (is_shift(alu_ctrl)) begin
        result_next  = op_a;
        illegal_next = 1'b0;
        sh_op_next   = alu_ctrl;
        cnt_next     = shamt;
        state_next   = (shamt == '0) ? S_DONE : S_SHIFT;
      end else begin
        result_next  = comb_result;
        illegal_next = comb_illegal;
        state_next   = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      result_reg  <= '0;
      illegal_reg <= 1'b0;
      cnt_reg     <= '0;
      sh_op_reg   <= ALU_SLL;
    end else begin
      state_reg   <= state_next;
      result_reg  <= result_next;
      illegal_reg <= illegal_next;
      cnt_reg     <= cnt_next;
      sh_op_reg   <= sh_op_next;
    end
  end

  assign out_valid = (state_reg == S_DONE);
  assign result    = result_reg;
  assign zero      = (result_reg == '0);
  assign illegal   = illegal_reg;

endmodule
